// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit (master)
// and the instruction memory (slave).
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register: PC, imem handshake, stall/redirect handling.
// Define FETCH_STAT_EN to add the fetch_count / bubble_count statistics outputs.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  if_fetch_unit_if.master imem,
  output logic [31:0] ReadInst,
  output logic [31:0] IF_PC_Plus_4,
  output logic        fetch_valid,
  output logic        hold,
`ifdef FETCH_STAT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count,
`endif
  output logic        flush
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_BUF  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_buf_reg, inst_buf_next;
  logic [31:0] tgt_pc_reg, tgt_pc_next;

  logic        req_raw;
  logic        valid_raw;
  logic [31:0] inst_raw;
  logic [31:0] redirect_tgt;
  logic [31:0] pc_plus_4;

  assign redirect_tgt = redirect_pc & ~32'h3;
  assign pc_plus_4    = pc_reg + 32'd4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_REQ;
      pc_reg       <= RESET_PC;
      inst_buf_reg <= '0;
      tgt_pc_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      inst_buf_reg <= inst_buf_next;
      tgt_pc_reg   <= tgt_pc_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    inst_buf_next = inst_buf_reg;
    tgt_pc_next   = tgt_pc_reg;
    req_raw       = 1'b0;
    valid_raw     = 1'b0;
    inst_raw      = '0;
    case (state_reg)
      S_REQ: begin
        req_raw = 1'b1;
        if (imem.imem_ack) begin
          if (redirect) begin
            pc_next = redirect_tgt;
          end else if (!stall) begin
            valid_raw = 1'b1;
            inst_raw  = imem.imem_rdata;
            pc_next   = pc_plus_4;
          end else begin
            inst_buf_next = imem.imem_rdata;
            state_next    = S_BUF;
          end
        end else if (redirect) begin
          // Request must stay on the bus until acked; remember where to go next.
          tgt_pc_next = redirect_tgt;
          state_next  = S_DROP;
        end
      end
      S_BUF: begin
        valid_raw = 1'b1;
        inst_raw  = inst_buf_reg;
        if (redirect) begin
          pc_next    = redirect_tgt;
          state_next = S_REQ;
        end else if (!stall) begin
          pc_next    = pc_plus_4;
          state_next = S_REQ;
        end
      end
      S_DROP: begin
        req_raw = 1'b1;
        if (redirect) begin
          tgt_pc_next = redirect_tgt;
        end
        if (imem.imem_ack) begin
          pc_next    = redirect ? redirect_tgt : tgt_pc_reg;
          state_next = S_REQ;
        end
      end
      default: begin
        state_next = S_REQ;
      end
    endcase
  end

  // Everything handed downstream is forced quiet while reset is held low.
  assign imem.imem_req  = reset & req_raw;
  assign imem.imem_addr = pc_reg;
  assign fetch_valid    = reset & valid_raw;
  assign ReadInst       = reset ? inst_raw : 32'd0;
  assign IF_PC_Plus_4   = pc_plus_4;
  assign hold           = reset & stall & ~redirect;
  assign flush          = reset & (redirect | (~fetch_valid & ~stall));

`ifdef FETCH_STAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (fetch_valid && !hold && !flush) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (flush) begin
        bubble_count <= bubble_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, randomized run against an
// address-stream scoreboard, and reset-during-request sequence.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ReadInst;
  logic [31:0] IF_PC_Plus_4;
  logic        fetch_valid;
  logic        hold;
  logic        flush;
`ifdef FETCH_STAT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  int total;
  int bad;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem         (bus.master),
    .ReadInst     (ReadInst),
    .IF_PC_Plus_4 (IF_PC_Plus_4),
    .fetch_valid  (fetch_valid),
    .hold         (hold),
`ifdef FETCH_STAT_EN
    .fetch_count  (fetch_count),
    .bubble_count (bubble_count),
`endif
    .flush        (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        fv;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        hold;
    logic        flush;
  } vec_t;

  localparam int NVEC = 15;
  vec_t tbl [NVEC];

  function automatic vec_t mk(logic s, logic r, logic [31:0] rpc, logic a, logic [31:0] rd,
                              logic rq, logic [31:0] ad, logic fv, logic [31:0] in,
                              logic [31:0] p4, logic h, logic f);
    vec_t v;
    v.stall = s; v.redirect = r; v.rpc = rpc; v.ack = a; v.rdata = rd;
    v.req = rq; v.addr = ad; v.fv = fv; v.inst = in; v.pc4 = p4; v.hold = h; v.flush = f;
    return v;
  endfunction

  function automatic logic [31:0] memf(logic [31:0] a);
    return 32'h2000_0001 + (a >> 2);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic        pend;
    logic [31:0] pend_addr;
    int          wait_cnt;
    int          lat;
    int          nfetch;
    int          guard;

    total = 0;
    bad   = 0;

    // Row-by-row expectations, starting with the first cycle after reset release.
    //               stall red rpc           ack rdata          req addr          fv inst           pc4           hold flush
    tbl[0]  = mk(0, 0, 32'h0,         1, 32'h2000_0001, 1, 32'h0,         1, 32'h2000_0001, 32'h4,        0, 0);
    tbl[1]  = mk(0, 0, 32'h0,         1, 32'h2000_0002, 1, 32'h4,         1, 32'h2000_0002, 32'h8,        0, 0);
    tbl[2]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h8,         0, 32'h0,         32'hC,        0, 1);
    tbl[3]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h8,         0, 32'h0,         32'hC,        0, 1);
    tbl[4]  = mk(0, 0, 32'h0,         1, 32'h2000_0003, 1, 32'h8,         1, 32'h2000_0003, 32'hC,        0, 0);
    tbl[5]  = mk(1, 0, 32'h0,         1, 32'h2000_0004, 1, 32'hC,         0, 32'h0,         32'h10,       1, 0);
    tbl[6]  = mk(1, 0, 32'h0,         0, 32'h0,         0, 32'hC,         1, 32'h2000_0004, 32'h10,       1, 0);
    tbl[7]  = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'hC,         1, 32'h2000_0004, 32'h10,       0, 0);
    tbl[8]  = mk(0, 1, 32'h100,       0, 32'h0,         1, 32'h10,        0, 32'h0,         32'h14,       0, 1);
    tbl[9]  = mk(0, 1, 32'h202,       0, 32'h0,         1, 32'h10,        0, 32'h0,         32'h14,       0, 1);
    tbl[10] = mk(0, 0, 32'h0,         1, 32'hDEAD_BEEF, 1, 32'h10,        0, 32'h0,         32'h14,       0, 1);
    tbl[11] = mk(1, 0, 32'h0,         1, 32'h2000_0041, 1, 32'h200,       0, 32'h0,         32'h204,      1, 0);
    tbl[12] = mk(1, 1, 32'hFFFF_FFFE, 0, 32'h0,         0, 32'h200,       1, 32'h2000_0041, 32'h204,      0, 1);
    tbl[13] = mk(0, 0, 32'h0,         1, 32'h1111_1111, 1, 32'hFFFF_FFFC, 1, 32'h1111_1111, 32'h0,        0, 0);
    tbl[14] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h4,        0, 1);

    // Reset held: outputs quiet even with inputs asserted.
    reset = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hCAFE_F00D;
    next_cycle();
    next_cycle();
    check("rst_req",   {31'd0, bus.imem_req}, 32'd0);
    check("rst_addr",  bus.imem_addr,         32'h0);
    check("rst_inst",  ReadInst,              32'h0);
    check("rst_pc4",   IF_PC_Plus_4,          32'h4);
    check("rst_fv",    {31'd0, fetch_valid},  32'd0);
    check("rst_hold",  {31'd0, hold},         32'd0);
    check("rst_flush", {31'd0, flush},        32'd0);
    #1 reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      stall = tbl[i].stall; redirect = tbl[i].redirect; redirect_pc = tbl[i].rpc;
      bus.imem_ack = tbl[i].ack; bus.imem_rdata = tbl[i].rdata;
      #1;
      check($sformatf("v%0d_req", i),   {31'd0, bus.imem_req}, {31'd0, tbl[i].req});
      check($sformatf("v%0d_addr", i),  bus.imem_addr,         tbl[i].addr);
      check($sformatf("v%0d_fv", i),    {31'd0, fetch_valid},  {31'd0, tbl[i].fv});
      if (tbl[i].fv) check($sformatf("v%0d_inst", i), ReadInst, tbl[i].inst);
      check($sformatf("v%0d_pc4", i),   IF_PC_Plus_4,          tbl[i].pc4);
      check($sformatf("v%0d_hold", i),  {31'd0, hold},         {31'd0, tbl[i].hold});
      check($sformatf("v%0d_flush", i), {31'd0, flush},        {31'd0, tbl[i].flush});
      $display("vec %0d: req=%b addr=%h fv=%b inst=%h pc4=%h hold=%b flush=%b",
               i, bus.imem_req, bus.imem_addr, fetch_valid, ReadInst, IF_PC_Plus_4, hold, flush);
      next_cycle();
    end
`ifdef FETCH_STAT_EN
    check("tbl_fetch_count",  fetch_count,  32'd5);
    check("tbl_bubble_count", bubble_count, 32'd7);
`endif

    // Fresh start for the randomized run.
    stall = 1'b0; redirect = 1'b0; bus.imem_ack = 1'b0;
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;

    exp_pc = 32'h0; pend = 1'b0; pend_addr = '0; wait_cnt = 0; lat = $urandom_range(0, 3); nfetch = 0;
    for (int c = 0; c < 3000; c++) begin
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom();
      bus.imem_ack   = bus.imem_req && (wait_cnt >= lat);
      bus.imem_rdata = bus.imem_ack ? memf(bus.imem_addr) : $urandom();
      #1;
      if (pend) begin
        check("req_kept",    {31'd0, bus.imem_req}, 32'd1);
        check("addr_stable", bus.imem_addr,         pend_addr);
      end
      check("rnd_hold",  {31'd0, hold},  {31'd0, stall & ~redirect});
      check("rnd_flush", {31'd0, flush}, {31'd0, redirect | (~fetch_valid & ~stall)});
      if (fetch_valid && !hold && !flush) begin
        check("rnd_pc4",  IF_PC_Plus_4, exp_pc + 32'd4);
        check("rnd_inst", ReadInst,     memf(exp_pc));
        exp_pc = exp_pc + 32'd4;
        nfetch++;
      end
      if (redirect) exp_pc = redirect_pc & ~32'h3;
      pend      = bus.imem_req && !bus.imem_ack;
      pend_addr = bus.imem_addr;
      if (bus.imem_req && !bus.imem_ack) wait_cnt++;
      else if (bus.imem_ack) begin
        wait_cnt = 0;
        lat = $urandom_range(0, 3);
      end
      next_cycle();
    end
    $display("random: %0d words delivered", nfetch);
    check("rnd_progress", {31'd0, nfetch > 300}, 32'd1);

    // Reset dropped while a request is outstanding.
    stall = 1'b0; redirect = 1'b0; bus.imem_ack = 1'b0;
    guard = 0;
    while (!bus.imem_req && guard < 20) begin
      next_cycle();
      guard++;
    end
    check("mid_req_before", {31'd0, bus.imem_req}, 32'd1);
    next_cycle();
    reset = 1'b0;
    #1;
    check("mid_req_drop", {31'd0, bus.imem_req}, 32'd0);
    check("mid_fv",       {31'd0, fetch_valid},  32'd0);
    check("mid_flush",    {31'd0, flush},        32'd0);
    next_cycle();
    reset = 1'b1;
    #1;
    check("restart_req",  {31'd0, bus.imem_req}, 32'd1);
    check("restart_addr", bus.imem_addr,         32'h0);
    check("restart_pc4",  IF_PC_Plus_4,          32'h4);
`ifdef FETCH_STAT_EN
    check("restart_fetch_count",  fetch_count,  32'd0);
    check("restart_bubble_count", bubble_count, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
